// File: rtl/als_spi_reader_if.sv
// als_spi_reader_if: request/SPI/sample bundle between the ALS reader and its neighbours.
interface als_spi_reader_if;
   logic       start;
   logic       SDO;
   logic       SCLK;
   logic       CS;
   logic [7:0] data;
   logic       valid;
   logic       err;
   logic       busy;
   modport master (input start, SDO, output SCLK, CS, data, valid, err, busy);
   modport slave  (output start, SDO, input SCLK, CS, data, valid, err, busy);
endinterface

// File: rtl/als_spi_reader.sv
// als_spi_reader: SPI mode-3 read master, one 16-bit frame per start, 8-bit sample out.
module als_spi_reader #(
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = 16,
   parameter int DATA_MSB   = 12,
   parameter int DATA_LSB   = 5
) (
   input  logic clk,
   input  logic rst,
   als_spi_reader_if.master bus
);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
   localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, QUIET = 3'd4;
   logic [2:0]            state;
   logic [CW-1:0]         cnt;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic                  last;
   assign last = cnt == CW'(CLK_DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         bus.SCLK  <= 1'b1;
         bus.CS    <= 1'b1;
         bus.data  <= '0;
         bus.valid <= 1'b0;
         bus.err   <= 1'b0;
         bus.busy  <= 1'b0;
      end else begin
         bus.valid <= 1'b0;
         cnt       <= (state == IDLE || last) ? '0 : cnt + 1'b1;
         case (state)
            IDLE:
               if (bus.start) begin
                  state    <= SETUP;
                  bus.CS   <= 1'b0;
                  bus.busy <= 1'b1;
               end
            SETUP:
               if (last) begin
                  state    <= SHIFT;
                  bus.SCLK <= 1'b0;
                  bit_cnt  <= '0;
               end
            // each half-period ends on last; the rising half samples SDO
            SHIFT:
               if (last) begin
                  if (!bus.SCLK) begin
                     bus.SCLK <= 1'b1;
                     shift    <= {shift[FRAME_BITS-2:0], bus.SDO};
                  end else if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                     state <= HOLD;
                  end else begin
                     bus.SCLK <= 1'b0;
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
               end
            HOLD:
               if (last) begin
                  state     <= QUIET;
                  bus.CS    <= 1'b1;
                  bus.valid <= 1'b1;
                  bus.data  <= shift[DATA_MSB:DATA_LSB];
                  bus.err   <= |shift[FRAME_BITS-1:DATA_MSB+1];
               end
            QUIET:
               if (last) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_als_spi_reader.sv
// tb_als_spi_reader: three readers (CLK_DIV 1/2/5) against a frame-level reference model.
module tb_als_spi_reader;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_a, sclk_a, cs_a, valid_a, err_a, busy_a;
   logic [7:0] data_a [3];
   logic [15:0] frm [3];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int DV = g == 0 ? 1 : g == 1 ? 2 : 5;
      als_spi_reader_if bus_if ();
      als_spi_reader #(.CLK_DIV(DV)) dut (.clk(clk), .rst(rst), .bus(bus_if.master));
      logic sdo;
      int k;
      assign bus_if.start = start_a[g];
      assign bus_if.SDO   = sdo;
      assign sclk_a[g]    = bus_if.SCLK;
      assign cs_a[g]      = bus_if.CS;
      assign valid_a[g]   = bus_if.valid;
      assign err_a[g]     = bus_if.err;
      assign busy_a[g]    = bus_if.busy;
      assign data_a[g]    = bus_if.data;
      // peripheral: CS fall rewinds, each SCLK fall presents the next bit MSB first
      always @(negedge bus_if.CS or negedge bus_if.SCLK)
         if (!bus_if.CS) begin
            if (bus_if.SCLK) k = 0;
            else begin
               if (k < 16) sdo <= frm[g][15-k];
               k = k + 1;
            end
         end
   end
   function automatic int dv(input int n);
      return n == 0 ? 1 : n == 1 ? 2 : 5;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic wait_idle(input int n);
      for (int i = 0; i < 2000 && busy_a[n]; i++) @(negedge clk);
      chk($sformatf("idle%0d", n), busy_a[n], 0);
   endtask
   task automatic run_frame(input int n, input logic [15:0] f);
      int d, rises, vat, vn, bad_cs, bad_idle, bad_busy, bad_half, lrun, hrun;
      logic ps, ve;
      logic [7:0] vd;
      d = dv(n); frm[n] = f; wait_idle(n);
      rises = 0; vat = 0; vn = 0; bad_cs = 0; bad_idle = 0; bad_busy = 0; bad_half = 0;
      lrun = 0; hrun = 0; ps = 1'b1; ve = 1'b0; vd = '0;
      start_a[n] = 1'b1;
      @(negedge clk);
      start_a[n] = 1'b0;
      for (int l = 1; l <= 35*d+1; l++) begin
         if (cs_a[n] !== (l > 34*d)) bad_cs++;
         if (cs_a[n] && !sclk_a[n]) bad_idle++;
         if (busy_a[n] !== (l <= 35*d)) bad_busy++;
         if (sclk_a[n] && !ps) begin rises++; if (lrun != d) bad_half++; end
         if (!sclk_a[n] && ps && hrun != d) bad_half++;
         lrun = sclk_a[n] ? 0 : lrun + 1;
         hrun = sclk_a[n] ? hrun + 1 : 0;
         ps = sclk_a[n];
         if (valid_a[n]) begin vn++; vat = l; vd = data_a[n]; ve = err_a[n]; end
         if (l <= 35*d) @(negedge clk);
      end
      chk($sformatf("cs_win%0d", n), bad_cs, 0);
      chk($sformatf("sclk_idle%0d", n), bad_idle, 0);
      chk($sformatf("busy_win%0d", n), bad_busy, 0);
      chk($sformatf("rises%0d", n), rises, 16);
      chk($sformatf("half%0d", n), bad_half, 0);
      chk($sformatf("valid_n%0d", n), vn, 1);
      chk($sformatf("valid_at%0d", n), vat, 34*d+1);
      chk($sformatf("data%0d", n), vd, f[12:5]);
      chk($sformatf("err%0d", n), ve, |f[15:13]);
      chk($sformatf("data_hold%0d", n), data_a[n], f[12:5]);
   endtask
   task automatic back2back(input logic [15:0] f);
      int vc [$];
      int falls;
      logic pc;
      frm[1] = f; wait_idle(1);
      falls = 0; pc = cs_a[1];
      start_a[1] = 1'b1;
      for (int i = 0; i < 4*71 && vc.size() < 3; i++) begin
         @(negedge clk);
         if (pc && !cs_a[1]) falls++;
         pc = cs_a[1];
         if (valid_a[1]) begin
            vc.push_back(cyc);
            chk("b2b_data", data_a[1], f[12:5]);
         end
      end
      start_a[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pc && !cs_a[1]) falls++;
         pc = cs_a[1];
      end
      chk("b2b_n", vc.size(), 3);
      chk("b2b_falls", falls, 3);
      if (vc.size() == 3) begin
         chk("b2b_gap1", vc[1] - vc[0], 71);
         chk("b2b_gap2", vc[2] - vc[1], 71);
      end
   endtask
   task automatic reset_mid(input logic [15:0] f);
      int vn;
      frm[1] = f; wait_idle(1);
      start_a[1] = 1'b1;
      @(negedge clk);
      start_a[1] = 1'b0;
      repeat (31) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rmid_cs", cs_a[1], 1);
      chk("rmid_sclk", sclk_a[1], 1);
      chk("rmid_busy", busy_a[1], 0);
      chk("rmid_data", data_a[1], 0);
      chk("rmid_valid", valid_a[1], 0);
      @(negedge clk);
      rst = 1'b0;
      vn = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (valid_a[1]) vn++;
      end
      chk("rmid_novalid", vn, 0);
      chk("rmid_data_kept", data_a[1], 0);
   endtask
   initial begin
      rst = 1'b1;
      start_a = '0;
      for (int n = 0; n < 3; n++) frm[n] = '0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("rst_cs%0d", n), cs_a[n], 1);
         chk($sformatf("rst_sclk%0d", n), sclk_a[n], 1);
         chk($sformatf("rst_data%0d", n), data_a[n], 0);
         chk($sformatf("rst_valid%0d", n), valid_a[n], 0);
         chk($sformatf("rst_err%0d", n), err_a[n], 0);
         chk($sformatf("rst_busy%0d", n), busy_a[n], 0);
      end
      rst = 1'b0;
      @(negedge clk);
      run_frame(1, 16'h0B40);
      run_frame(1, 16'h8B40);
      run_frame(1, 16'h0000);
      back2back(16'h0B40);
      reset_mid(16'h1FE0);
      run_frame(1, 16'h0B40);
      for (int n = 0; n < 3; n += 2) begin
         run_frame(n, 16'h1FE0);
         run_frame(n, 16'h0020);
      end
      for (int i = 0; i < 4; i++)
         for (int n = 0; n < 3; n++) run_frame(n, 16'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
